// File: rtl/ahb_csr_bridge_if.sv
// AHB-Lite bus bundle between a master (fabric or bench) and the CSR bridge slave.
interface ahb_csr_bridge_if #(parameter int DW = 32);
    logic          hselx;
    logic          hready;
    logic [31:0]   haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [3:0]    hprot;
    logic [DW-1:0] hwdata;
    logic [DW-1:0] hrdata;
    logic          hready_out;
    logic          hresp;

    modport master (
        output hselx, hready, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
        input  hrdata, hready_out, hresp
    );

    modport slave (
        input  hselx, hready, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
        output hrdata, hready_out, hresp
    );
endinterface

// File: rtl/ahb_csr_bridge.sv
// AHB-Lite slave converting each accepted transfer into a single CSR-bus strobe.
// Define AHB_CSR_ERR_EN to answer out-of-window/unaligned/oversized transfers with ERROR.
//
//  state   | meaning
//  IDLE    | no data phase in progress
//  WR      | write data phase, csr_wr issued with hwdata
//  RD_WAIT | read issued, waiting RD_LAT clocks for csr_rdata
//  RD_DONE | read data returned on hrdata
//  ERR1    | first ERROR cycle, bus stalled
//  ERR2    | second ERROR cycle, bus released
module ahb_csr_bridge #(
    parameter int          DW     = 32,
    parameter int          CSR_AW = 12,
    parameter logic [31:0] BASE   = 32'h0,
    parameter int          RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    ahb_csr_bridge_if.slave     bus,
    output logic                csr_wr,
    output logic                csr_rd,
    output logic [CSR_AW-1:0]   csr_addr,
    output logic [DW-1:0]       csr_wdata,
    output logic [DW/8-1:0]     csr_wstrb,
    input  logic [DW-1:0]       csr_rdata
);
    localparam int NB = DW/8;
    localparam int LB = $clog2(NB);
    localparam logic [1:0] CNT_LD = 2'(RD_LAT - 1);
    localparam logic [CSR_AW-1:0] LANE_MASK = CSR_AW'(NB - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR      = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] RD_DONE = 3'd3;
    localparam logic [2:0] ERR1    = 3'd4;
    localparam logic [2:0] ERR2    = 3'd5;

`ifdef AHB_CSR_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic [2:0]        state, state_nx;
    logic [1:0]        cnt;
    logic [CSR_AW-1:0] addr_q;
    logic [NB-1:0]     strb_q, strb_nx;
    logic              drop_q;
    logic [DW-1:0]     hrdata_q;
    logic              take, in_win, unaligned, size_ok, bad;
    logic [6:0]        amask;
    logic              unused;

    assign unused = ^{bus.hburst, bus.hprot, bus.htrans[0]};

    // Only states that present hready_out=1 may take a new address phase.
    assign take      = bus.hselx & bus.hready & bus.htrans[1] & bus.hready_out;
    assign in_win    = (bus.haddr[31:CSR_AW] == BASE[31:CSR_AW]);
    assign amask     = (7'd1 << bus.hsize) - 7'd1;
    assign unaligned = |(bus.haddr[6:0] & amask);
    assign size_ok   = (bus.hsize <= 3'(LB));
    assign bad       = !in_win | unaligned | !size_ok;

    always_comb begin
        int off;
        int nby;
        strb_nx = '0;
        off = int'(bus.haddr[LB-1:0]);
        nby = 1 << bus.hsize;
        for (int i = 0; i < NB; i++)
            strb_nx[i] = (i >= off) && (i < off + nby);
    end

    always_comb begin
        state_nx = state;
        case (state)
            RD_WAIT: if (cnt == 2'd0) state_nx = RD_DONE;
            ERR1:    state_nx = ERR2;
            default: begin
                if (!take)                state_nx = IDLE;
                else if (bad && ERR_EN)   state_nx = ERR1;
                else if (bus.hwrite)      state_nx = WR;
                else if (bad)             state_nx = RD_DONE;
                else                      state_nx = RD_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            addr_q   <= '0;
            strb_q   <= '0;
            drop_q   <= 1'b0;
            hrdata_q <= '0;
        end else begin
            state <= state_nx;
            if (take) begin
                addr_q <= bus.haddr[CSR_AW-1:0] & ~LANE_MASK;
                strb_q <= strb_nx;
                drop_q <= bad;
                cnt    <= CNT_LD;
            end else if (state == RD_WAIT && cnt != 2'd0) begin
                cnt <= cnt - 2'd1;
            end
            if (state == RD_DONE)
                hrdata_q <= drop_q ? '0 : csr_rdata;
        end
    end

    assign csr_wr     = (state == WR) && !drop_q;
    assign csr_rd     = (state == RD_WAIT) && (cnt == CNT_LD);
    assign csr_addr   = addr_q;
    assign csr_wdata  = csr_wr ? bus.hwdata : '0;
    assign csr_wstrb  = (csr_wr | csr_rd) ? strb_q : '0;

    assign bus.hready_out = !(state == RD_WAIT || state == ERR1);
    assign bus.hrdata     = (state == RD_DONE) ? (drop_q ? '0 : csr_rdata) : hrdata_q;
`ifdef AHB_CSR_ERR_EN
    assign bus.hresp      = (state == ERR1) || (state == ERR2);
`else
    assign bus.hresp      = 1'b0;
`endif
endmodule

// File: tb/tb_ahb_csr_bridge.sv
// Directed bench for ahb_csr_bridge: 32-bit/RD_LAT=2 and 64-bit/RD_LAT=1 instances.
module tb_ahb_csr_bridge;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ahb_csr_bridge_if #(.DW(32)) b32();
    ahb_csr_bridge_if #(.DW(64)) b64();
    assign b32.hready = b32.hready_out;
    assign b64.hready = b64.hready_out;

    logic        c_wr, c_rd;
    logic [11:0] c_addr;
    logic [31:0] c_wdata, c_rdata, stg;
    logic [3:0]  c_wstrb;
    logic        d_wr, d_rd;
    logic [11:0] d_addr;
    logic [63:0] d_wdata;
    logic [63:0] d_rdata = 64'h0;
    logic [7:0]  d_wstrb;

    ahb_csr_bridge #(.DW(32), .CSR_AW(12), .BASE(32'h0), .RD_LAT(2)) u32 (
        .clk(clk), .rst_n(rst_n), .bus(b32), .csr_wr(c_wr), .csr_rd(c_rd), .csr_addr(c_addr),
        .csr_wdata(c_wdata), .csr_wstrb(c_wstrb), .csr_rdata(c_rdata));

    ahb_csr_bridge #(.DW(64), .CSR_AW(12), .BASE(32'h0), .RD_LAT(1)) u64 (
        .clk(clk), .rst_n(rst_n), .bus(b64), .csr_wr(d_wr), .csr_rd(d_rd), .csr_addr(d_addr),
        .csr_wdata(d_wdata), .csr_wstrb(d_wstrb), .csr_rdata(d_rdata));

    // CSR register file model: byte-lane writes, two-clock read pipeline.
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 64; k++) mem[k] <= 32'h0;
            stg     <= 32'h0;
            c_rdata <= 32'h0;
        end else begin
            if (c_wr)
                for (int k = 0; k < 4; k++)
                    if (c_wstrb[k]) mem[c_addr[7:2]][8*k +: 8] <= c_wdata[8*k +: 8];
            if (c_rd) stg <= mem[c_addr[7:2]];
            c_rdata <= stg;
        end
    end

    int wr_cnt = 0, rd_cnt = 0;
    logic [11:0] rd_q[$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (c_wr) wr_cnt++;
            if (c_rd) begin rd_cnt++; rd_q.push_back(c_addr); end
        end
    end

    int n_cmp = 0, n_bad = 0;

    // Drive one address phase on b32 and return once it has been taken (hready high).
    task automatic issue(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                         input logic wr, input logic [2:0] size,
                         output logic frdy, output logic fresp, output logic [31:0] lrdata,
                         output int ncyc);
        logic done;
        b32.hselx = sel; b32.haddr = addr; b32.htrans = trans;
        b32.hwrite = wr; b32.hsize = size; b32.hburst = 3'd1;
        done = 1'b0; ncyc = 0; frdy = 1'b0; fresp = 1'b0; lrdata = 32'h0;
        while (!done && ncyc < 20) begin
            @(negedge clk);
            if (ncyc == 0) begin frdy = b32.hready_out; fresp = b32.hresp; end
            lrdata = b32.hrdata;
            done = b32.hready_out;
            ncyc++;
            @(posedge clk); #1;
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_timeout: hready_out stuck at %b for %0d cycles, want 1", done, ncyc);
        end
    endtask

    task automatic test_reset();
        b32.hselx = 0; b32.haddr = 0; b32.htrans = 0; b32.hwrite = 0; b32.hsize = 0;
        b32.hburst = 0; b32.hprot = 0; b32.hwdata = 0;
        b64.hselx = 0; b64.haddr = 0; b64.htrans = 0; b64.hwrite = 0; b64.hsize = 0;
        b64.hburst = 0; b64.hprot = 0; b64.hwdata = 0;
        rst_n = 1'b1; #1 rst_n = 1'b0; #1;
        n_cmp++; if (b32.hready_out !== 1'b1) begin n_bad++; $display("FAIL rst_hready: got %b want 1", b32.hready_out); end
        n_cmp++; if (b32.hresp !== 1'b0) begin n_bad++; $display("FAIL rst_hresp: got %b want 0", b32.hresp); end
        n_cmp++; if (b32.hrdata !== 32'h0) begin n_bad++; $display("FAIL rst_hrdata: got %h want 0", b32.hrdata); end
        n_cmp++; if ({c_wr, c_rd} !== 2'b00) begin n_bad++; $display("FAIL rst_strobes: got %b want 00", {c_wr, c_rd}); end
        n_cmp++; if ({c_addr, c_wdata, c_wstrb} !== 48'h0) begin n_bad++; $display("FAIL rst_csr_bus: got %h want 0", {c_addr, c_wdata, c_wstrb}); end
        n_cmp++; if ({b64.hready_out, d_wstrb} !== 9'h100) begin n_bad++; $display("FAIL rst_dw64: got %h want 100", {b64.hready_out, d_wstrb}); end
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic fr, fs; logic [31:0] rd; int nc;
        issue(1, 32'h10, 2'd2, 1, 3'd2, fr, fs, rd, nc);
        b32.hwdata = 32'hA5A5_1234;
        b32.haddr = 32'h10; b32.htrans = 2'd2; b32.hwrite = 0; b32.hsize = 3'd2;
        @(negedge clk);
        n_cmp++; if ({c_wr, c_wstrb, c_addr} !== {1'b1, 4'hF, 12'h010}) begin n_bad++; $display("FAIL wr_strobe: got %h want 1f010", {c_wr, c_wstrb, c_addr}); end
        n_cmp++; if (c_wdata !== 32'hA5A5_1234) begin n_bad++; $display("FAIL wr_data: got %h want a5a51234", c_wdata); end
        @(posedge clk); #1;
        issue(0, 32'h0, 2'd0, 0, 3'd2, fr, fs, rd, nc);
        n_cmp++; if (nc !== 3) begin n_bad++; $display("FAIL rd_latency: got %0d want 3", nc); end
        n_cmp++; if (fr !== 1'b0) begin n_bad++; $display("FAIL rd_first_wait: got %b want 0", fr); end
        n_cmp++; if (rd !== 32'hA5A5_1234) begin n_bad++; $display("FAIL rd_data: got %h want a5a51234", rd); end
        n_cmp++; if ({wr_cnt, rd_cnt} !== {32'd1, 32'd1}) begin n_bad++; $display("FAIL rw_counts: got %0d/%0d want 1/1", wr_cnt, rd_cnt); end
        @(negedge clk);
        n_cmp++; if (b32.hrdata !== 32'hA5A5_1234) begin n_bad++; $display("FAIL rd_hold: got %h want a5a51234", b32.hrdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_write();
        logic fr, fs; logic [31:0] rd; int nc;
        issue(1, 32'h13, 2'd2, 1, 3'd0, fr, fs, rd, nc);
        b32.hwdata = 32'h7700_0000;
        b32.hselx = 0; b32.htrans = 2'd0;
        @(negedge clk);
        n_cmp++; if ({c_wr, c_wstrb} !== 5'b1_1000) begin n_bad++; $display("FAIL byte_strb: got %b want 11000", {c_wr, c_wstrb}); end
        n_cmp++; if (c_addr !== 12'h010) begin n_bad++; $display("FAIL byte_addr: got %h want 010", c_addr); end
        n_cmp++; if (c_wdata[31:24] !== 8'h77) begin n_bad++; $display("FAIL byte_data: got %h want 77", c_wdata[31:24]); end
        @(posedge clk); #1;
        issue(1, 32'h10, 2'd2, 0, 3'd2, fr, fs, rd, nc);
        issue(0, 32'h0, 2'd0, 0, 3'd2, fr, fs, rd, nc);
        n_cmp++; if (rd !== 32'h77A5_1234) begin n_bad++; $display("FAIL byte_merge: got %h want 77a51234", rd); end
    endtask

    task automatic test_burst();
        logic fr, fs; logic [31:0] rd; int nc;
        issue(1, 32'h2C, 2'd2, 1, 3'd2, fr, fs, rd, nc);
        b32.hwdata = 32'hDEAD_BEEF;
        issue(0, 32'h0, 2'd0, 0, 3'd2, fr, fs, rd, nc);
        rd_q.delete();
        issue(1, 32'h20, 2'd2, 0, 3'd2, fr, fs, rd, nc);
        issue(1, 32'h24, 2'd3, 0, 3'd2, fr, fs, rd, nc);
        issue(1, 32'h28, 2'd1, 0, 3'd2, fr, fs, rd, nc);
        issue(1, 32'h28, 2'd3, 0, 3'd2, fr, fs, rd, nc);
        n_cmp++; if ({fr, fs} !== 2'b10) begin n_bad++; $display("FAIL busy_okay: got rdy/resp %b want 10", {fr, fs}); end
        n_cmp++; if (nc !== 1) begin n_bad++; $display("FAIL busy_zero_wait: got %0d want 1", nc); end
        issue(1, 32'h2C, 2'd3, 0, 3'd2, fr, fs, rd, nc);
        issue(0, 32'h0, 2'd0, 0, 3'd2, fr, fs, rd, nc);
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL burst_last_data: got %h want deadbeef", rd); end
        n_cmp++; if (rd_q.size() !== 4) begin n_bad++; $display("FAIL burst_count: got %0d want 4", rd_q.size()); end
        else begin
            n_cmp++;
            if ({rd_q[0], rd_q[1], rd_q[2], rd_q[3]} !== 48'h020_024_028_02C) begin
                n_bad++; $display("FAIL burst_addrs: got %h want 02002402802c", {rd_q[0], rd_q[1], rd_q[2], rd_q[3]});
            end
        end
    endtask

    task automatic test_bad_access();
        logic fr, fs; logic [31:0] rd; int nc, r0, w0;
        r0 = rd_cnt; w0 = wr_cnt;
`ifdef AHB_CSR_ERR_EN
        issue(1, 32'h1000, 2'd2, 0, 3'd2, fr, fs, rd, nc);
        b32.hselx = 0; b32.htrans = 2'd0;
        @(negedge clk);
        n_cmp++; if ({b32.hresp, b32.hready_out} !== 2'b10) begin n_bad++; $display("FAIL err1: got resp/rdy %b want 10", {b32.hresp, b32.hready_out}); end
        @(posedge clk); #1;
        b32.hselx = 1; b32.haddr = 32'h10; b32.htrans = 2'd2; b32.hwrite = 0; b32.hsize = 3'd2;
        @(negedge clk);
        n_cmp++; if ({b32.hresp, b32.hready_out} !== 2'b11) begin n_bad++; $display("FAIL err2: got resp/rdy %b want 11", {b32.hresp, b32.hready_out}); end
        @(posedge clk); #1;
        issue(0, 32'h0, 2'd0, 0, 3'd2, fr, fs, rd, nc);
        n_cmp++; if ({fs, nc} !== {1'b0, 32'd3}) begin n_bad++; $display("FAIL after_err_read: got resp %b cycles %0d want 0/3", fs, nc); end
        n_cmp++; if (rd !== 32'h77A5_1234) begin n_bad++; $display("FAIL after_err_data: got %h want 77a51234", rd); end
        n_cmp++; if (rd_cnt !== r0 + 1) begin n_bad++; $display("FAIL err_no_rd: got %0d want %0d", rd_cnt, r0 + 1); end
        issue(1, 32'h11, 2'd2, 1, 3'd2, fr, fs, rd, nc);
        b32.hwdata = 32'h5555_5555;
        issue(0, 32'h0, 2'd0, 0, 3'd2, fr, fs, rd, nc);
        n_cmp++; if ({fr, fs, nc} !== {1'b0, 1'b1, 32'd2}) begin n_bad++; $display("FAIL unaligned_err: got rdy %b resp %b cycles %0d want 0/1/2", fr, fs, nc); end
`else
        issue(1, 32'h1000, 2'd2, 0, 3'd2, fr, fs, rd, nc);
        issue(0, 32'h0, 2'd0, 0, 3'd2, fr, fs, rd, nc);
        n_cmp++; if ({fr, fs, nc} !== {1'b1, 1'b0, 32'd1}) begin n_bad++; $display("FAIL oow_read_okay: got rdy %b resp %b cycles %0d want 1/0/1", fr, fs, nc); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL oow_read_zero: got %h want 0", rd); end
        n_cmp++; if (rd_cnt !== r0) begin n_bad++; $display("FAIL oow_no_rd: got %0d want %0d", rd_cnt, r0); end
        issue(1, 32'h1010, 2'd2, 1, 3'd2, fr, fs, rd, nc);
        b32.hwdata = 32'h1111_1111;
        issue(0, 32'h0, 2'd0, 0, 3'd2, fr, fs, rd, nc);
        n_cmp++; if ({fs, nc} !== {1'b0, 32'd1}) begin n_bad++; $display("FAIL oow_write_okay: got resp %b cycles %0d want 0/1", fs, nc); end
        issue(1, 32'h10, 2'd2, 0, 3'd2, fr, fs, rd, nc);
        issue(0, 32'h0, 2'd0, 0, 3'd2, fr, fs, rd, nc);
        n_cmp++; if (rd !== 32'h77A5_1234) begin n_bad++; $display("FAIL oow_write_dropped: got %h want 77a51234", rd); end
`endif
        n_cmp++; if (wr_cnt !== w0) begin n_bad++; $display("FAIL bad_no_wr: got %0d want %0d", wr_cnt, w0); end
    endtask

    task automatic test_reset_mid();
        logic fr, fs; logic [31:0] rd; int nc, w0;
        issue(1, 32'h10, 2'd2, 0, 3'd2, fr, fs, rd, nc);
        b32.hselx = 0; b32.htrans = 2'd0;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (b32.hready_out !== 1'b0) begin n_bad++; $display("FAIL mid_rd_wait: got %b want 0", b32.hready_out); end
        #1 rst_n = 1'b0; #1;
        n_cmp++; if ({b32.hready_out, b32.hresp} !== 2'b10) begin n_bad++; $display("FAIL mid_rst_outputs: got rdy/resp %b want 10", {b32.hready_out, b32.hresp}); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (b32.hrdata !== 32'h0) begin n_bad++; $display("FAIL mid_rst_hrdata: got %h want 0", b32.hrdata); end
        @(posedge clk); #1;
        w0 = wr_cnt;
        issue(1, 32'h30, 2'd2, 1, 3'd2, fr, fs, rd, nc);
        b32.hwdata = 32'h0BAD_F00D;
        issue(0, 32'h0, 2'd0, 0, 3'd2, fr, fs, rd, nc);
        n_cmp++; if ({nc, wr_cnt} !== {32'd1, w0 + 32'd1}) begin n_bad++; $display("FAIL post_rst_write: got cycles %0d writes %0d want 1/%0d", nc, wr_cnt, w0 + 1); end
    endtask

    task automatic test_dw64();
        b64.hselx = 1; b64.haddr = 32'h8; b64.htrans = 2'd2; b64.hwrite = 1; b64.hsize = 3'd3;
        @(posedge clk); #1;
        b64.hwdata = 64'h1122_3344_5566_7788;
        b64.haddr = 32'hC; b64.hsize = 3'd2;
        @(negedge clk);
        n_cmp++; if ({d_wr, d_wstrb, d_addr} !== {1'b1, 8'hFF, 12'h008}) begin n_bad++; $display("FAIL dw64_dword: got %h want 1ff008", {d_wr, d_wstrb, d_addr}); end
        @(posedge clk); #1;
        b64.hwdata = 64'hCAFE_0001_0000_0000;
        b64.hselx = 0; b64.htrans = 2'd0;
        @(negedge clk);
        n_cmp++; if ({d_wr, d_wstrb, d_addr} !== {1'b1, 8'hF0, 12'h008}) begin n_bad++; $display("FAIL dw64_word_hi: got %h want 1f0008", {d_wr, d_wstrb, d_addr}); end
        n_cmp++; if (d_wdata[63:32] !== 32'hCAFE_0001) begin n_bad++; $display("FAIL dw64_wdata: got %h want cafe0001", d_wdata[63:32]); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_write();
        test_burst();
        test_bad_access();
        test_reset_mid();
        test_dw64();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
